fp_operand_aligner: RTL and testbench

//  Front-end stage of the FP adder. Unpacks two IEEE-754 operands, compares magnitudes, swaps so the larger

---
 rtl/fp_operand_aligner.sv | 161 ++++++++++++++++
 tb/tb_fp_operand_aligner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_operand_aligner.sv
// FP adder front end: unpacks two operands, orders them by magnitude and right-aligns the smaller
// mantissa with guard/round/sticky. Two-stage valid/ready pipeline with no skid buffer.
module fp_operand_aligner #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   sa,
    output logic                   sb,
    output logic                   a_lt_b,
    output logic                   eff_sub,
    output logic [EXP_W-1:0]       exp_max,
    output logic [MAN_W:0]         man_big,
    output logic [MAN_W+3:0]       man_small_al,
    output logic                   special
);

    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned AL_W = MAN_W + 4;

    // Unpack
    logic [EXP_W-1:0] exp_a_f, exp_b_f, eexp_a, eexp_b;
    logic [MAN_W:0]   full_a, full_b;
    logic             lt_c, special_c;
    logic [EXP_W-1:0] exp_big_c, exp_small_c, d_c;
    logic [MAN_W:0]   big_c, small_c;

    always_comb begin
        exp_a_f   = a[W-2 -: EXP_W];
        exp_b_f   = b[W-2 -: EXP_W];
        eexp_a    = (|exp_a_f) ? exp_a_f : EXP_W'(1);
        eexp_b    = (|exp_b_f) ? exp_b_f : EXP_W'(1);
        full_a    = {|exp_a_f, a[MAN_W-1:0]};
        full_b    = {|exp_b_f, b[MAN_W-1:0]};
        // Raw {exp,man} fields order identically to magnitude, denormals included.
        lt_c      = a[W-2:0] < b[W-2:0];
        special_c = (&exp_a_f) | (&exp_b_f);
        if (lt_c) begin
            exp_big_c   = eexp_b;
            exp_small_c = eexp_a;
            big_c       = full_b;
            small_c     = full_a;
        end else begin
            exp_big_c   = eexp_a;
            exp_small_c = eexp_b;
            big_c       = full_a;
            small_c     = full_b;
        end
        d_c = exp_big_c - exp_small_c;
    end

    // Handshake
    logic v1_q, v2_q, adv1, adv2, accept, load2;

    always_comb begin
        adv2     = ~v2_q | out_ready;
        adv1     = ~v1_q | adv2;
        in_ready = adv1;
        accept   = in_valid & adv1;
        load2    = adv2 & v1_q;
    end

    // Stage 1 registers
    logic             s1_sa_q, s1_sb_q, s1_lt_q, s1_special_q;
    logic [EXP_W-1:0] s1_exp_q, s1_d_q;
    logic [MAN_W:0]   s1_big_q, s1_small_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q         <= 1'b0;
            s1_sa_q      <= 1'b0;
            s1_sb_q      <= 1'b0;
            s1_lt_q      <= 1'b0;
            s1_special_q <= 1'b0;
            s1_exp_q     <= '0;
            s1_d_q       <= '0;
            s1_big_q     <= '0;
            s1_small_q   <= '0;
        end else begin
            if (adv1) begin
                v1_q <= in_valid;
            end
            if (accept) begin
                s1_sa_q      <= a[W-1];
                s1_sb_q      <= b[W-1];
                s1_lt_q      <= lt_c;
                s1_special_q <= special_c;
                s1_exp_q     <= exp_big_c;
                s1_d_q       <= d_c;
                s1_big_q     <= big_c;
                s1_small_q   <= small_c;
            end
        end
    end

    // Alignment shift with sticky collection
    logic [AL_W-1:0] ext, lost, al_c;

    always_comb begin
        ext  = {s1_small_q, 3'b000};
        lost = '0;
        if (32'(s1_d_q) >= AL_W) begin
            al_c = {{(AL_W-1){1'b0}}, |s1_small_q};
        end else begin
            lost = ext & ~({AL_W{1'b1}} << s1_d_q);
            al_c = (ext >> s1_d_q) | {{(AL_W-1){1'b0}}, |lost};
        end
    end

    // Stage 2 (output) registers
    logic             sa_q, sb_q, lt_q, special_q;
    logic [EXP_W-1:0] exp_q;
    logic [MAN_W:0]   big_q;
    logic [AL_W-1:0]  al_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2_q      <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            lt_q      <= 1'b0;
            special_q <= 1'b0;
            exp_q     <= '0;
            big_q     <= '0;
            al_q      <= '0;
        end else begin
            if (adv2) begin
                v2_q <= v1_q;
            end
            if (load2) begin
                sa_q      <= s1_sa_q;
                sb_q      <= s1_sb_q;
                lt_q      <= s1_lt_q;
                special_q <= s1_special_q;
                exp_q     <= s1_exp_q;
                big_q     <= s1_big_q;
                al_q      <= al_c;
            end
        end
    end

    always_comb begin
        out_valid    = v2_q;
        sa           = sa_q;
        sb           = sb_q;
        a_lt_b       = lt_q;
        eff_sub      = sa_q ^ sb_q;
        exp_max      = exp_q;
        man_big      = big_q;
        man_small_al = al_q;
        special      = special_q;
    end

endmodule

// File: tb/tb_fp_operand_aligner.sv
// Self-checking bench for fp_operand_aligner: directed literal cases, backpressure stream,
// mid-flight reset and randomized traffic against an arithmetic reference model.
module tb_fp_operand_aligner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] a, b;
    logic        sa, sb, a_lt_b, eff_sub, special;
    logic [7:0]  exp_max;
    logic [23:0] man_big;
    logic [26:0] man_small_al;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    fp_operand_aligner #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .sa(sa), .sb(sb), .a_lt_b(a_lt_b),
        .eff_sub(eff_sub), .exp_max(exp_max), .man_big(man_big), .man_small_al(man_small_al),
        .special(special)
    );

    always #5 clk = ~clk;

    wire [63:0] got = {sa, sb, a_lt_b, eff_sub, exp_max, man_big, man_small_al, special};

    function automatic logic [63:0] pack(input logic s_a, s_b, lt, es, input int e,
                                         input longint unsigned big, al, input logic sp);
        logic [7:0]  e8;
        logic [23:0] b24;
        logic [26:0] a27;
        e8  = e[7:0];
        b24 = big[23:0];
        a27 = al[26:0];
        return {s_a, s_b, lt, es, e8, b24, a27, sp};
    endfunction

    // Reference: values taken as real magnitudes, shift done as integer division.
    function automatic logic [63:0] model(input logic [31:0] x, y);
        int ex, ey, eb, es, d;
        longint unsigned mx, my, mb, ms, ext, al;
        logic lt;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = longint'(x[22:0]) + ((ex != 0) ? 64'd8388608 : 64'd0);
        my = longint'(y[22:0]) + ((ey != 0) ? 64'd8388608 : 64'd0);
        if (ex == 0) ex = 1;
        if (ey == 0) ey = 1;
        lt = (x[30:0] < y[30:0]);
        if (lt) begin eb = ey; es = ex; mb = my; ms = mx; end
        else    begin eb = ex; es = ey; mb = mx; ms = my; end
        d   = eb - es;
        ext = ms * 8;
        if (d >= 27) al = (ms != 0) ? 1 : 0;
        else al = (ext / (64'd1 << d)) | (((ext % (64'd1 << d)) != 0) ? 64'd1 : 64'd0);
        return pack(x[31], y[31], lt, x[31] ^ y[31], eb, mb, al,
                    (x[30:23] == 8'hFF) || (y[30:23] == 8'hFF));
    endfunction

    task automatic chk(input string name, input logic [63:0] g, e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, g, e);
        end
    endtask

    task automatic chk1(input string name, input logic g, e);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, g, e);
        end
    endtask

    // Scoreboard: every valid output cycle must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h expected=none", got);
                end else begin
                    chk("scoreboard", got, exp_q[0]);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b));
        end
    end

    function automatic logic [31:0] rand_op(input int near);
        int e, m;
        logic [22:0] man;
        m   = int'($urandom_range(0, 9));
        man = 23'($urandom);
        if ($urandom_range(0, 7) == 0) man = '0;
        if (m == 0)      e = 0;
        else if (m == 1) e = 255;
        else if (m < 7) begin
            e = near + int'($urandom_range(0, 62)) - 31;
            if (e < 0) e = 0;
            if (e > 255) e = 255;
        end else e = int'($urandom_range(0, 255));
        return {1'($urandom), 8'(e), man};
    endfunction

    task automatic directed(input string name, input logic [31:0] x, y, input logic [63:0] e);
        int n;
        chk({name, "_model"}, model(x, y), e);
        a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'd2);
        chk(name, got, e);
        @(posedge clk); #1;
    endtask

    logic [31:0] sa_op[8], sb_op[8];

    initial begin
        int idx, k;
        logic acc;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        #12;
        chk1("reset_out_valid", out_valid, 1'b0);
        chk1("reset_in_ready", in_ready, 1'b1);
        chk("reset_data", got, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        directed("t1_equal", 32'h3F800000, 32'h3F800000,
                 pack(0, 0, 0, 0, 127, 64'h800000, 64'h4000000, 0));
        directed("t2_swap", 32'h3F800000, 32'hC0000000,
                 pack(0, 1, 1, 1, 128, 64'h800000, 64'h2000000, 0));
        directed("t3_d24", 32'h4B800000, 32'h3F800000,
                 pack(0, 0, 0, 0, 151, 64'h800000, 64'h4, 0));
        directed("t3_d30", 32'h4E800000, 32'h3F800001,
                 pack(0, 0, 0, 0, 157, 64'h800000, 64'h1, 0));
        directed("t4_denorm", 32'h00000003, 32'h00000001,
                 pack(0, 0, 0, 0, 1, 64'h3, 64'h8, 0));
        directed("t6_special", 32'h7F800000, 32'h00000000,
                 pack(0, 0, 0, 0, 255, 64'h800000, 64'h0, 1));

        // Back-to-back stream with a backpressure window
        for (int i = 0; i < 8; i++) begin
            sa_op[i] = rand_op(127);
            sb_op[i] = rand_op(int'(sa_op[i][30:23]));
        end
        idx = 0; k = 0;
        while (idx < 8 && k < 40) begin
            a = sa_op[idx]; b = sb_op[idx]; in_valid = 1'b1;
            out_ready = !(k >= 3 && k <= 6);
            @(negedge clk);
            acc = in_ready;
            if (k >= 3 && k <= 6) chk1("stream_in_ready_full", in_ready, 1'b0);
            @(posedge clk); #1;
            if (acc) idx++;
            k++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        chk("stream_drain", 64'(exp_q.size()), 64'd0);

        // Reset with two operations in flight
        a = rand_op(100); b = rand_op(100); in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        a = rand_op(100); b = rand_op(100);
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk1("rst_mid_out_valid", out_valid, 1'b0);
        exp_q.delete();
        @(posedge clk); #3;
        rst_n = 1'b1;
        chk1("rst_release_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk1("rst_no_stale", out_valid, 1'b0);
        end

        // Randomized traffic
        in_valid = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!in_valid || acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                a = rand_op(int'($urandom_range(0, 255)));
                b = rand_op(int'(a[30:23]));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 20) begin @(posedge clk); #1; k++; end
        chk("random_drain", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
